// File: rtl/bus_rq_ack_pkg.sv
// Shared types and constants for the req/ack bus referee and its arbiter.
package bus_rq_ack_pkg;

  localparam int unsigned DEF_REQ_DATA_WIDTH = 8;
  localparam int unsigned DEF_ACK_DATA_WIDTH = 8;

  localparam logic [DEF_ACK_DATA_WIDTH-1:0] ERR_ACK = '1;

  typedef logic client_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SREQ,
    ST_ACK,
    ST_DROP
  } ref_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-client round-robin grant: on a tie the client that did not win last time wins.
module rr_arbiter2
  import bus_rq_ack_pkg::*;
(
  input  logic [1:0]  req,
  input  client_idx_t last_grant,
  output logic        valid,
  output client_idx_t grant
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (&req) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/bus_referee_rq_ack.sv
// Two-client req/ack bus referee: round-robin serialisation onto one server port,
// with a timeout that returns an all-ones error acknowledge.
module bus_referee_rq_ack
  import bus_rq_ack_pkg::*;
#(
  parameter int unsigned REQ_DATA_WIDTH = DEF_REQ_DATA_WIDTH,
  parameter int unsigned ACK_DATA_WIDTH = DEF_ACK_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      client0_req,
  input  logic [REQ_DATA_WIDTH-1:0] client0_data_req,
  output logic                      client0_ack,
  output logic [ACK_DATA_WIDTH-1:0] client0_data_ack,
  input  logic                      client1_req,
  input  logic [REQ_DATA_WIDTH-1:0] client1_data_req,
  output logic                      client1_ack,
  output logic [ACK_DATA_WIDTH-1:0] client1_data_ack,
  output logic                      server_req,
  output logic [REQ_DATA_WIDTH-1:0] server_data_req,
  input  logic                      server_ack,
  input  logic [ACK_DATA_WIDTH-1:0] server_data_ack
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  ref_state_t                state;
  client_idx_t               grant;
  client_idx_t               last_grant;
  logic [7:0]                cnt;

  logic                      arb_valid;
  client_idx_t               arb_grant;
  logic [REQ_DATA_WIDTH-1:0] fwd_data;
  logic [ACK_DATA_WIDTH-1:0] ack_data;
  logic                      sreq_done;
  logic                      granted_req;

  rr_arbiter2 u_arb (
    .req        ({client1_req, client0_req}),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  // Top request-data bit is replaced by the originating client index.
  always_comb begin
    fwd_data = arb_grant ? client1_data_req : client0_data_req;
    fwd_data[REQ_DATA_WIDTH-1] = arb_grant;
  end

  // A real server_ack takes priority over a timeout landing in the same cycle.
  always_comb begin
    sreq_done   = server_ack || (cnt == TIMEOUT_LAST);
    ack_data    = server_ack ? server_data_ack : '1;
    granted_req = grant ? client1_req : client0_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      cnt              <= '0;
      server_req       <= 1'b0;
      server_data_req  <= '0;
      client0_ack      <= 1'b0;
      client0_data_ack <= '0;
      client1_ack      <= 1'b0;
      client1_data_ack <= '0;
    end else begin
      client0_ack      <= 1'b0;
      client0_data_ack <= '0;
      client1_ack      <= 1'b0;
      client1_data_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant           <= arb_grant;
            server_req      <= 1'b1;
            server_data_req <= fwd_data;
            cnt             <= '0;
            state           <= ST_SREQ;
          end
        end
        ST_SREQ: begin
          cnt <= cnt + 8'd1;
          if (sreq_done) begin
            server_req <= 1'b0;
            if (grant) begin
              client1_ack      <= 1'b1;
              client1_data_ack <= ack_data;
            end else begin
              client0_ack      <= 1'b1;
              client0_data_ack <= ack_data;
            end
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          last_grant <= grant;
          cnt        <= '0;
          state      <= ST_DROP;
        end
        ST_DROP: begin
          if (!granted_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_referee_rq_ack.md
Name: bus_referee_rq_ack

Overview:
- Bus referee (arbiter) sitting directly downstream of client0_rq_ack and client1_rq_ack.
- Accepts req/ack transactions from two clients and serialises them onto one server port, using round-robin arbitration.
- Returns the server's acknowledge data to the granted client.
- Aborts a hung server transaction with an error acknowledge after a timeout.

Parameters:
- REQ_DATA_WIDTH, 8, width of request data; bit [REQ_DATA_WIDTH-1] carries the originating client index.
- ACK_DATA_WIDTH, 8, width of acknowledge data.
- TIMEOUT_CYCLES, 16, maximum SREQ cycles to wait for server_ack before an error acknowledge; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- client0_req  input  1  client 0 request, held high until acknowledged
- client0_data_req  input  REQ_DATA_WIDTH  client 0 request data, stable while client0_req=1
- client0_ack  output  1  one-cycle acknowledge to client 0
- client0_data_ack  output  ACK_DATA_WIDTH  acknowledge data, valid when client0_ack=1
- client1_req  input  1  client 1 request
- client1_data_req  input  REQ_DATA_WIDTH  client 1 request data
- client1_ack  output  1  one-cycle acknowledge to client 1
- client1_data_ack  output  ACK_DATA_WIDTH  acknowledge data to client 1
- server_req  output  1  forwarded request, held high until server_ack
- server_data_req  output  REQ_DATA_WIDTH  forwarded request data
- server_ack  input  1  one-cycle server acknowledge
- server_data_ack  input  ACK_DATA_WIDTH  server acknowledge data, valid with server_ack

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst_n.
- All outputs are registered. Reset values:
  - all acks, data outputs and server_req = 0
  - state = IDLE, last_grant = 1 (so client 0 wins the first tie), timeout counter = 0
- FSM states: IDLE, SREQ, ACK, DROP.
- IDLE:
  - If any req is high, grant the requester.
  - If both are high, grant the client not equal to last_grant.
  - Register grant index and its request data. Overwrite bit [REQ_DATA_WIDTH-1] with the grant index. Go to SREQ.
- SREQ:
  - server_req=1, server_data_req held constant; timeout counter increments every cycle.
  - On server_ack=1: latch server_data_ack, drop server_req, go to ACK.
  - On counter reaching TIMEOUT_CYCLES-1 without server_ack: latch all-ones error data, drop server_req, go to ACK.
  - If server_ack and the timeout coincide, server_ack wins and real data is returned.
- ACK:
  - Granted client's ack=1 for exactly one cycle, with latched data on its data_ack. The other client's ack and data_ack stay 0.
  - Set last_grant = grant, clear the counter, go to DROP.
- DROP:
  - Wait until the granted client's req=0, then go to IDLE.
  - This prevents a still-high req from being re-granted. The other client's req is ignored until IDLE.
- client data_ack outputs return to 0 when ack is low.
- A server_ack arriving outside SREQ is ignored.
- Latency: req high at IDLE edge N → server_req high from cycle N+1.
  - server_ack sampled at edge M → client ack high in cycle M+1.
  - Minimum req-to-ack is 3 cycles.
- A client dropping req while in SREQ is a protocol violation. The referee completes the transaction regardless.
- Reset mid-transaction returns all outputs to reset values on the next edge. No ack is issued for the aborted transaction.

Decomposition:
- Shared package bus_rq_ack_pkg holds:
  - FSM state enum (IDLE, SREQ, ACK, DROP), 2 bits
  - client index type (1 bit)
  - ERR_ACK constant (all ones)
  - default widths (8/8)
- One natural sub-module: rr_arbiter2, a combinational 2-input round-robin grant from req vector and last_grant. All other logic stays in the top.

Test Plan:
- Single request: client0_req=1, data 0x85; server acks 2 cycles after server_req with 0x3C.
  - server_data_req=0x05 (bit 7 forced to 0).
  - client0_ack one cycle, client0_data_ack=0x3C, client1_ack never asserted.
- Simultaneous requests after reset: both reqs high, both clients hold req until acked.
  - Client 0 served first, then client 1 (server_data_req bit7=1).
  - Next tie goes to client 0.
- Timeout: client1_req=1, server never acks.
  - server_req high exactly 16 cycles, then client1_ack with data 0xFF.
- Ack/timeout coincidence: server_ack=1 with 0x11 on cycle 16 of SREQ.
  - Client receives 0x11, not 0xFF.
- Held req: client0 keeps req high 5 cycles after ack.
  - No second server_req until req falls; client1 waiting is granted first after IDLE.
- Reset mid-SREQ: rst_n=0 for one cycle.
  - server_req=0 on the next edge, no client ack issued, FSM in IDLE, last_grant=1.
